// File: rtl/m_mem_arbiter_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
// Owner encoding tags which port the in-flight read belongs to.
package m_mem_arbiter_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

endpackage

// File: rtl/m_mem_arbiter_starve_cnt.sv
// Saturating counter with synchronous clear, used to track how long the
// instruction port has been denied while requesting.
module m_starve_cnt #(
    parameter int MAX = 3,
    parameter int W   = $clog2(MAX + 1)
) (
    input  logic         w_clk,
    input  logic         w_rst_n,
    input  logic         w_en,
    input  logic         w_inc,
    input  logic         w_clr,
    output logic [W-1:0] r_cnt
);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_cnt <= '0;
        end else if (w_en) begin
            if (w_clr) begin
                r_cnt <= '0;
            end else if (w_inc && (r_cnt != W'(MAX))) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/m_mem_arbiter.sv
// Arbitrates one single-port synchronous memory between the read-only
// instruction port and the read/write data port of the core.
module m_mem_arbiter
    import m_mem_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = 32
) (
    input  logic              w_clk,
    input  logic              w_rst_n,
    input  logic              w_ce,
    input  logic              w_i_valid,
    input  logic [ADDR_W-1:0] w_i_addr,
    output logic              w_i_ready,
    output logic              w_i_rvalid,
    output logic [DATA_W-1:0] w_i_rdata,
    input  logic              w_d_valid,
    input  logic              w_d_we,
    input  logic [ADDR_W-1:0] w_d_addr,
    input  logic [DATA_W-1:0] w_d_wdata,
    output logic              w_d_ready,
    output logic              w_d_rvalid,
    output logic [DATA_W-1:0] w_d_rdata,
    output logic [ADDR_W-1:0] w_m_addr,
    output logic              w_m_we,
    output logic [DATA_W-1:0] w_m_wdata,
    input  logic [DATA_W-1:0] w_m_rdata,
    output logic [CNT_W-1:0]  r_conf_cnt
);

    localparam int STW = $clog2(STARVE_MAX + 1);

    logic [STW-1:0] r_starve;
    owner_e         r_owner;
    owner_e         owner_nxt;
    logic           grant_i;
    logic           grant_d;
    logic           starve_hit;

    assign starve_hit = (r_starve == STW'(STARVE_MAX));

    // D has fixed priority unless I has already waited the full budget.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (w_ce) begin
            if (w_i_valid && starve_hit) begin
                grant_i = 1'b1;
            end else if (w_d_valid) begin
                grant_d = 1'b1;
            end else if (w_i_valid) begin
                grant_i = 1'b1;
            end
        end
    end

    assign w_i_ready = grant_i;
    assign w_d_ready = grant_d;
    assign w_m_addr  = grant_d ? w_d_addr : w_i_addr;
    assign w_m_we    = grant_d && w_d_we;
    assign w_m_wdata = w_d_wdata;

    m_starve_cnt #(
        .MAX (STARVE_MAX),
        .W   (STW)
    ) u_starve (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .w_en    (w_ce),
        .w_inc   (w_i_valid && !grant_i),
        .w_clr   (grant_i || !w_i_valid),
        .r_cnt   (r_starve)
    );

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_owner <= OWN_NONE;
        end else begin
            r_owner <= owner_nxt;
        end
    end

    // Owner holds while disabled so a pending response stays visible.
    always_comb begin
        owner_nxt = r_owner;
        if (w_ce) begin
            owner_nxt = OWN_NONE;
            if (grant_i) begin
                owner_nxt = OWN_I;
            end else if (grant_d && !w_d_we) begin
                owner_nxt = OWN_D;
            end
        end
    end

    assign w_i_rvalid = (r_owner == OWN_I);
    assign w_d_rvalid = (r_owner == OWN_D);
    assign w_i_rdata  = w_m_rdata;
    assign w_d_rdata  = w_m_rdata;

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_conf_cnt <= '0;
        end else if (w_ce && w_i_valid && w_d_valid) begin
            r_conf_cnt <= r_conf_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Scoreboard bench for m_mem_arbiter: directed grant vectors plus a monitor
// that matches every read response against the queue of expected responses.
module tb_m_mem_arbiter;
    import m_mem_arbiter_pkg::*;

    localparam int CNT_W = 4;

    logic              w_clk;
    logic              w_rst_n;
    logic              w_ce;
    logic              w_i_valid;
    logic [11:0]       w_i_addr;
    logic              w_i_ready;
    logic              w_i_rvalid;
    logic [31:0]       w_i_rdata;
    logic              w_d_valid;
    logic              w_d_we;
    logic [11:0]       w_d_addr;
    logic [31:0]       w_d_wdata;
    logic              w_d_ready;
    logic              w_d_rvalid;
    logic [31:0]       w_d_rdata;
    logic [11:0]       w_m_addr;
    logic              w_m_we;
    logic [31:0]       w_m_wdata;
    logic [31:0]       w_m_rdata;
    logic [CNT_W-1:0]  r_conf_cnt;

    typedef struct packed {
        logic        port;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    owner_e      exp_owner;
    int          vectors = 0;
    int          errors  = 0;
    logic [31:0] wmem [logic [11:0]];

    m_mem_arbiter #(
        .STARVE_MAX (3),
        .CNT_W      (CNT_W)
    ) dut (
        .w_clk      (w_clk),
        .w_rst_n    (w_rst_n),
        .w_ce       (w_ce),
        .w_i_valid  (w_i_valid),
        .w_i_addr   (w_i_addr),
        .w_i_ready  (w_i_ready),
        .w_i_rvalid (w_i_rvalid),
        .w_i_rdata  (w_i_rdata),
        .w_d_valid  (w_d_valid),
        .w_d_we     (w_d_we),
        .w_d_addr   (w_d_addr),
        .w_d_wdata  (w_d_wdata),
        .w_d_ready  (w_d_ready),
        .w_d_rvalid (w_d_rvalid),
        .w_d_rdata  (w_d_rdata),
        .w_m_addr   (w_m_addr),
        .w_m_we     (w_m_we),
        .w_m_wdata  (w_m_wdata),
        .w_m_rdata  (w_m_rdata),
        .r_conf_cnt (r_conf_cnt)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    function automatic logic [31:0] patternWord(input logic [11:0] a);
        return {20'hC0DE0, a};
    endfunction

    // Only 0x100 is ever read back after being written.
    function automatic logic [31:0] expWord(input logic [11:0] a);
        return (a == 12'h100) ? 32'hDEADBEEF : patternWord(a);
    endfunction

    // Memory model with registered read; reads return the pre-write word.
    always @(posedge w_clk) begin
        if (w_ce) begin
            w_m_rdata <= wmem.exists(w_m_addr) ? wmem[w_m_addr] : patternWord(w_m_addr);
            if (w_m_we) wmem[w_m_addr] = w_m_wdata;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Response monitor: a response is consumed on each enabled cycle it is shown.
    always @(negedge w_clk) begin
        if (w_rst_n && w_ce && (w_i_rvalid || w_d_rvalid)) begin
            rsp_t e;
            if (w_i_rvalid && w_d_rvalid) begin
                vectors++;
                errors++;
                $display("[TB] FAIL rsp_both: got both rvalids, expected one at %0t", $time);
            end
            if (exp_q.size() == 0) begin
                vectors++;
                errors++;
                $display("[TB] FAIL rsp_unexpected: got rvalid i=%b d=%b, expected none at %0t",
                         w_i_rvalid, w_d_rvalid, $time);
            end else begin
                e = exp_q.pop_front();
                checkOutput("rsp_port", {31'd0, w_d_rvalid}, {31'd0, e.port});
                checkOutput("rsp_data", w_i_rvalid ? w_i_rdata : w_d_rdata, e.data);
            end
        end
    end

    // One cycle: drive inputs, check grant outputs mid-cycle, queue responses.
    task automatic applyStimulus(input logic ce, input logic iv, input logic [11:0] ia,
                                 input logic dv, input logic dwe, input logic [11:0] da,
                                 input logic [31:0] wd, input logic exp_ir, input logic exp_dr);
        w_ce      = ce;
        w_i_valid = iv;
        w_i_addr  = ia;
        w_d_valid = dv;
        w_d_we    = dwe;
        w_d_addr  = da;
        w_d_wdata = wd;
        @(negedge w_clk);
        checkOutput("i_ready", {31'd0, w_i_ready}, {31'd0, exp_ir});
        checkOutput("d_ready", {31'd0, w_d_ready}, {31'd0, exp_dr});
        checkOutput("m_we", {31'd0, w_m_we}, {31'd0, exp_dr && dwe});
        checkOutput("m_addr", {20'd0, w_m_addr}, {20'd0, exp_dr ? da : ia});
        checkOutput("m_wdata", w_m_wdata, wd);
        checkOutput("i_rvalid", {31'd0, w_i_rvalid}, {31'd0, exp_owner == OWN_I});
        checkOutput("d_rvalid", {31'd0, w_d_rvalid}, {31'd0, exp_owner == OWN_D});
        if (exp_ir) exp_q.push_back('{port: 1'b0, data: expWord(ia)});
        if (exp_dr && !dwe) exp_q.push_back('{port: 1'b1, data: expWord(da)});
        if (ce) exp_owner = exp_ir ? OWN_I : ((exp_dr && !dwe) ? OWN_D : OWN_NONE);
        @(posedge w_clk);
        #1;
    endtask

    task automatic idleCycle();
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 32'h0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic ir;
        exp_owner = OWN_NONE;
        w_rst_n   = 1'b0;
        w_ce      = 1'b1;
        w_i_valid = 1'b0;
        w_i_addr  = '0;
        w_d_valid = 1'b0;
        w_d_we    = 1'b0;
        w_d_addr  = '0;
        w_d_wdata = '0;
        @(posedge w_clk);
        #2;
        checkOutput("rst_i_rvalid", {31'd0, w_i_rvalid}, 32'd0);
        checkOutput("rst_d_rvalid", {31'd0, w_d_rvalid}, 32'd0);
        checkOutput("rst_conf", {28'd0, r_conf_cnt}, 32'd0);
        checkOutput("rst_starve", {30'd0, dut.r_starve}, 32'd0);
        #4 w_rst_n = 1'b1;
        @(posedge w_clk);
        #1;

        // I alone at 0x010: granted every cycle, responses one cycle later.
        repeat (4) applyStimulus(1'b1, 1'b1, 12'h010, 1'b0, 1'b0, 12'h000, 32'h0, 1'b1, 1'b0);
        checkOutput("t1_conf", {28'd0, r_conf_cnt}, 32'd0);

        // D write then read-back of 0x100.
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b1, 1'b1, 12'h100, 32'hDEADBEEF, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 12'h000, 1'b1, 1'b0, 12'h100, 32'h0, 1'b0, 1'b1);
        idleCycle();

        // Ten conflict cycles: D,D,D,I,D,D,D,I,D,D.
        for (int k = 0; k < 10; k++) begin
            ir = (k == 3) || (k == 7);
            applyStimulus(1'b1, 1'b1, 12'h020, 1'b1, 1'b0, 12'h030, 32'h0, ir, !ir);
        end
        checkOutput("t3_conf", {28'd0, r_conf_cnt}, 32'd10);
        checkOutput("t3_starve", {30'd0, dut.r_starve}, 32'd2);

        // Clock enable low for two cycles with a D read response pending.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b0, 1'b1, 12'h020, 1'b1, 1'b1, 12'h040, 32'h12345678, 1'b0, 1'b0);
            checkOutput("ce_conf", {28'd0, r_conf_cnt}, 32'd10);
            checkOutput("ce_starve", {30'd0, dut.r_starve}, 32'd2);
        end
        applyStimulus(1'b1, 1'b1, 12'h020, 1'b1, 1'b1, 12'h040, 32'h12345678, 1'b0, 1'b1);
        checkOutput("ce_starve_sat", {30'd0, dut.r_starve}, 32'd3);
        applyStimulus(1'b1, 1'b1, 12'h020, 1'b1, 1'b1, 12'h040, 32'h12345678, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 12'h020, 1'b1, 1'b1, 12'h040, 32'h12345678, 1'b0, 1'b1);
        idleCycle();
        checkOutput("ce_conf_after", {28'd0, r_conf_cnt}, 32'd12);

        // Async reset in the response cycle of a D read.
        applyStimulus(1'b1, 1'b1, 12'h020, 1'b1, 1'b0, 12'h050, 32'h0, 1'b0, 1'b1);
        checkOutput("pre_rst_d_rvalid", {31'd0, w_d_rvalid}, 32'd1);
        checkOutput("pre_rst_conf", {28'd0, r_conf_cnt}, 32'd13);
        #2;
        w_rst_n   = 1'b0;
        w_i_valid = 1'b0;
        w_d_valid = 1'b0;
        #1;
        checkOutput("async_d_rvalid", {31'd0, w_d_rvalid}, 32'd0);
        checkOutput("async_i_rvalid", {31'd0, w_i_rvalid}, 32'd0);
        checkOutput("async_conf", {28'd0, r_conf_cnt}, 32'd0);
        checkOutput("async_starve", {30'd0, dut.r_starve}, 32'd0);
        exp_q.delete();
        exp_owner = OWN_NONE;
        @(posedge w_clk);
        #3 w_rst_n = 1'b1;
        @(posedge w_clk);
        #1;
        idleCycle();
        checkOutput("post_rst_conf", {28'd0, r_conf_cnt}, 32'd0);

        // Sixteen conflicts wrap the 4-bit counter; pattern stays D,D,D,I.
        for (int k = 0; k < 16; k++) begin
            ir = (k % 4) == 3;
            applyStimulus(1'b1, 1'b1, 12'h060, 1'b1, 1'b0, 12'h070, 32'h0, ir, !ir);
            if (k == 14) checkOutput("wrap_conf_15", {28'd0, r_conf_cnt}, 32'd15);
        end
        checkOutput("wrap_conf_0", {28'd0, r_conf_cnt}, 32'd0);
        idleCycle();
        idleCycle();
        checkOutput("queue_empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/m_mem_arbiter.md
Name: m_mem_arbiter

Overview:
- Shares one single-port synchronous memory between the instruction-fetch port (I, read-only) and the data port (D, read/write) of the pipelined core.
- The memory has m_memory timing: 12-bit word address and a registered read with 1-cycle latency.
- Grants at most one request per cycle. D has fixed priority, with an anti-starvation override for I.
- Routes read data back to the port that issued the read, and counts conflict cycles for performance monitoring.

Parameters:
- STARVE_MAX, 3: consecutive cycles I may be denied while valid before I is forced to win.
- CNT_W, 32: width of the conflict counter.

Ports:
- w_clk  input  1  clock, rising edge
- w_rst_n  input  1  asynchronous active-low reset
- w_ce  input  1  clock enable; when low, no grants and all state holds
- w_i_valid  input  1  I-port read request
- w_i_addr  input  12  I-port word address
- w_i_ready  output  1  I request granted this cycle
- w_i_rvalid  output  1  I read data valid
- w_i_rdata  output  32  I read data
- w_d_valid  input  1  D-port request
- w_d_we  input  1  D request is a write
- w_d_addr  input  12  D-port word address
- w_d_wdata  input  32  D write data
- w_d_ready  output  1  D request granted this cycle
- w_d_rvalid  output  1  D read data valid (reads only)
- w_d_rdata  output  32  D read data
- w_m_addr  output  12  memory address
- w_m_we  output  1  memory write enable
- w_m_wdata  output  32  memory write data
- w_m_rdata  input  32  memory read data, registered, valid 1 cycle after a read address is presented
- r_conf_cnt  output  CNT_W  number of cycles in which both ports were valid

Behaviour:
- Reset (async, w_rst_n=0):
  - r_starve=0, r_owner=NONE, r_conf_cnt=0.
  - w_i_rvalid=0 and w_d_rvalid=0 immediately.
  - A read in flight at reset is dropped; no rvalid is produced for it after reset release.
- Grant (combinational, same cycle):
  - If w_ce=0: both readys are 0 and w_m_we=0.
  - Else if w_i_valid and r_starve==STARVE_MAX: grant I.
  - Else if w_d_valid: grant D.
  - Else if w_i_valid: grant I.
  - Else: no grant.
- Memory drive:
  - w_m_addr = granted port's address; with no grant, w_m_addr = w_i_addr.
  - w_m_we = D granted and w_d_we.
  - w_m_wdata = w_d_wdata at all times.
- Handshake:
  - A request transfers on (valid && ready).
  - Requesters must hold valid, addr, we and wdata stable until ready.
  - Ready may rise without waiting on any other handshake signal; there is no combinational path from rvalid to ready.
- Response:
  - r_owner is registered each enabled cycle: I if an I read was granted, D if a D read was granted, NONE otherwise (writes give NONE).
  - w_i_rvalid = (r_owner==I); w_d_rvalid = (r_owner==D).
  - w_i_rdata and w_d_rdata are both wired to w_m_rdata; rvalid qualifies them.
  - Read latency is exactly 1 cycle after grant. Back-to-back grants give back-to-back responses.
  - If w_ce is low on the response cycle, r_owner holds, so rvalid stays asserted until an enabled edge.
- Starvation counter (updates only when w_ce=1):
  - If w_i_valid and I is not granted: r_starve increments, saturating at STARVE_MAX.
  - If I is granted, or w_i_valid=0: r_starve clears to 0.
- Worst case: I waits STARVE_MAX cycles and is granted on cycle STARVE_MAX+1.
- Conflict counter: increments when w_ce && w_i_valid && w_d_valid. It wraps modulo 2^CNT_W with no saturation.
- Read/write ordering:
  - A D write granted in cycle t is visible to any read granted in cycle t+1 or later.
  - The arbiter does no forwarding.
- Simultaneous events:
  - On a tie, D wins unless the override is active.
  - While the override is active, D's ready is 0 even for a write.
- Reset release mid-burst: arbitration restarts with r_starve=0.

Decomposition:
- Shared package holds:
  - owner encoding: NONE=2'd0, I=2'd1, D=2'd2
  - address width 12
  - data width 32
- One natural sub-module is m_starve_cnt, the saturating counter with clear. Everything else stays flat in m_mem_arbiter.

Test Plan:
- Reset with w_i_valid=1, w_i_addr=0x010 held, D idle.
  - I granted every cycle.
  - w_i_rvalid rises 1 cycle after the first grant.
  - rdata equals mem[0x010].
  - r_conf_cnt stays 0.
- D write 0xDEADBEEF to 0x100, then D read of 0x100 on the next cycle.
  - w_d_rvalid one cycle after the read grant, with w_d_rdata=0xDEADBEEF.
  - No w_i_rvalid.
- I and D valid continuously for 10 cycles with STARVE_MAX=3.
  - Grant pattern D,D,D,I,D,D,D,I,D,D.
  - r_conf_cnt=10.
  - Each rvalid goes to the correct port.
- w_ce=0 for 2 cycles with both valid and a read in flight.
  - Readys are 0 and w_m_we=0.
  - rvalid holds, and r_starve and r_conf_cnt are unchanged.
- Assert w_rst_n=0 asynchronously (between clock edges) in the cycle after a D read is granted.
  - w_d_rvalid drops immediately.
  - No response appears after release.
  - Counters read 0.
- Preload r_conf_cnt near all-ones (force, or CNT_W=4 with 16 conflicts).
  - Counter wraps to 0.
  - Arbitration is unaffected.
